// File: rtl/eth_dest_filter.sv
// Ethernet destination-address filter: decides pass/drop on the first beat of each
// frame and forwards passed beats through a single registered AXI-Stream stage.
module eth_dest_filter #(
    parameter int DATA_W   = 64,
    parameter int NUM_ADDR = 4,
    parameter int USER_W   = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [DATA_W/8-1:0]     in_keep,
    input  logic                    in_last,
    input  logic [USER_W-1:0]       in_user,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [DATA_W/8-1:0]     out_keep,
    output logic                    out_last,
    output logic [USER_W-1:0]       out_user,
    input  logic [48*NUM_ADDR-1:0]  addr_table,
    input  logic [NUM_ADDR-1:0]     addr_enable,
    input  logic                    accept_broadcast,
    input  logic                    accept_multicast,
    input  logic                    promiscuous,
    input  logic                    count_clear,
    output logic [31:0]             pass_count,
    output logic [31:0]             drop_count
);

    typedef enum logic [1:0] {FIRST, PASS, DROP} state_t;

    state_t state;
    state_t next_state;

    logic take;
    logic runt;
    logic ucast;
    logic bcast;
    logic mcast;
    logic match;
    logic first_take;
    logic pass_beat;

    // The register can accept a new beat whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign take     = in_valid && in_ready;

    always_comb begin
        ucast = 1'b0;
        for (int i = 0; i < NUM_ADDR; i++) begin
            if (addr_enable[i] && (in_data[47:0] == addr_table[48*i +: 48])) begin
                ucast = 1'b1;
            end
        end
    end

    assign runt  = in_keep[5:0] != 6'h3f;
    assign bcast = accept_broadcast && (in_data[47:0] == 48'hffff_ffff_ffff);
    assign mcast = accept_multicast && in_data[0] && (in_data[47:0] != 48'hffff_ffff_ffff);
    assign match = !runt && (promiscuous || ucast || bcast || mcast);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= FIRST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (take) begin
            unique case (state)
                FIRST:      if (!in_last) next_state = match ? PASS : DROP;
                PASS, DROP: if (in_last) next_state = FIRST;
                default:    next_state = FIRST;
            endcase
        end
    end

    always_comb begin
        first_take = take && (state == FIRST);
        pass_beat  = take && (((state == FIRST) && match) || (state == PASS));
    end

    // A passed beat always reloads the register, even while the old one drains.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
        end else if (pass_beat) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_last  <= in_last;
            out_user  <= in_user;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // count_clear wins over an increment that lands in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset || count_clear) begin
            pass_count <= '0;
            drop_count <= '0;
        end else if (first_take) begin
            if (match) begin
                pass_count <= pass_count + 32'd1;
            end else begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_dest_filter.sv
// Randomized bench for eth_dest_filter: a frame-level acceptance model feeds a
// scoreboard of expected output beats and expected pass/drop counts.
module tb_eth_dest_filter;

    localparam int DATA_W   = 64;
    localparam int NUM_ADDR = 4;
    localparam int USER_W   = 1;
    localparam int KEEP_W   = DATA_W / 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [USER_W-1:0] user;
    } beat_t;

    logic                    Clock = 1'b0;
    logic                    Reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data = '0;
    logic [KEEP_W-1:0]       in_keep = '0;
    logic                    in_last = 1'b0;
    logic [USER_W-1:0]       in_user = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [DATA_W-1:0]       out_data;
    logic [KEEP_W-1:0]       out_keep;
    logic                    out_last;
    logic [USER_W-1:0]       out_user;
    logic [48*NUM_ADDR-1:0]  addr_table = '0;
    logic [NUM_ADDR-1:0]     addr_enable = '0;
    logic                    accept_broadcast = 1'b0;
    logic                    accept_multicast = 1'b0;
    logic                    promiscuous = 1'b0;
    logic                    count_clear = 1'b0;
    logic [31:0]             pass_count;
    logic [31:0]             drop_count;

    eth_dest_filter #(
        .DATA_W   (DATA_W),
        .NUM_ADDR (NUM_ADDR),
        .USER_W   (USER_W)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_keep          (in_keep),
        .in_last          (in_last),
        .in_user          (in_user),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_keep         (out_keep),
        .out_last         (out_last),
        .out_user         (out_user),
        .addr_table       (addr_table),
        .addr_enable      (addr_enable),
        .accept_broadcast (accept_broadcast),
        .accept_multicast (accept_multicast),
        .promiscuous      (promiscuous),
        .count_clear      (count_clear),
        .pass_count       (pass_count),
        .drop_count       (drop_count)
    );

    always #5 Clock = ~Clock;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic [31:0] m_pass = '0;
    logic [31:0] m_drop = '0;
    bit          in_frame = 1'b0;
    bit          frame_pass = 1'b0;
    bit          lat_pending = 1'b0;
    beat_t       lat_beat;
    bit          mon_en = 1'b0;
    bit          rand_ready = 1'b0;
    bit          stalled = 1'b0;
    logic [127:0] stall_vec = '0;

    localparam logic [47:0] ENTRY0 = 48'h0100_0000_0002;
    localparam logic [47:0] BCAST  = 48'hffff_ffff_ffff;
    localparam logic [47:0] MCAST  = 48'h0100_005e_0001;
    localparam logic [47:0] OTHER  = 48'h5544_3322_1100;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic finishTest();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    endtask

    function automatic logic [127:0] packBeat(input beat_t b);
        return 128'({b.data, b.keep, b.last, b.user});
    endfunction

    function automatic logic [127:0] outVec();
        return 128'({out_data, out_keep, out_last, out_user});
    endfunction

    // Frame acceptance from the rules: six address bytes present, then any enabled reason.
    function automatic bit modelMatch(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k);
        logic [47:0] dst;
        bit runt;
        bit hit;
        dst  = d[47:0];
        runt = 1'b0;
        for (int b = 0; b < 6; b++) if (!k[b]) runt = 1'b1;
        hit = promiscuous;
        for (int i = 0; i < NUM_ADDR; i++) begin
            if (addr_enable[i] && dst == addr_table[48*i +: 48]) hit = 1'b1;
        end
        if (dst == BCAST) begin
            if (accept_broadcast) hit = 1'b1;
        end else if (dst[0]) begin
            if (accept_multicast) hit = 1'b1;
        end
        return !runt && hit;
    endfunction

    task automatic applyStimulus(input beat_t bt, input int max_gap);
        int guard;
        if (max_gap > 0) begin
            repeat ($urandom_range(0, max_gap)) begin
                in_valid = 1'b0;
                @(negedge Clock);
            end
        end
        in_valid = 1'b1;
        in_data  = bt.data;
        in_keep  = bt.keep;
        in_last  = bt.last;
        in_user  = bt.user;
        guard    = 0;
        #1;
        while (!in_ready) begin
            @(negedge Clock);
            #1;
            guard++;
            if (guard > 200) begin
                checkOutput("in_ready_timeout", 128'(in_ready), 128'(1));
                finishTest();
            end
        end
        @(posedge Clock);
        if (!in_frame) begin
            frame_pass = modelMatch(bt.data, bt.keep);
            if (count_clear) begin
                m_pass = '0;
                m_drop = '0;
            end else if (frame_pass) begin
                m_pass = m_pass + 32'd1;
            end else begin
                m_drop = m_drop + 32'd1;
            end
        end
        if (frame_pass) begin
            exp_q.push_back(bt);
            lat_beat    = bt;
            lat_pending = 1'b1;
        end
        in_frame = !bt.last;
        @(negedge Clock);
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [47:0] dst, input int nbeats, input logic [KEEP_W-1:0] first_keep,
                             input int max_gap);
        beat_t bt;
        for (int b = 0; b < nbeats; b++) begin
            bt.data = {$urandom, $urandom};
            bt.keep = 8'hff;
            if (b == 0) begin
                bt.data[47:0] = dst;
                bt.keep = first_keep;
            end else if (b == nbeats - 1) begin
                bt.keep = 8'(8'hff >> $urandom_range(0, 7));
            end
            bt.last = (b == nbeats - 1);
            bt.user = 1'($urandom);
            applyStimulus(bt, max_gap);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge Clock);
        #1;
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_pass_count"}, 128'(pass_count), 128'(m_pass));
        checkOutput({tag, "_drop_count"}, 128'(drop_count), 128'(m_drop));
        checkOutput({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
    endtask

    always @(negedge Clock) begin
        out_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
    end

    // Output monitor: latency of passed beats, scoreboard order, stall stability.
    always @(negedge Clock) begin
        beat_t bt;
        #2;
        if (mon_en) begin
            checkOutput("in_ready_rule", 128'(in_ready), 128'(!out_valid || out_ready));
            if (lat_pending) begin
                checkOutput("latency_valid", 128'(out_valid), 128'(1));
                checkOutput("latency_beat", outVec(), packBeat(lat_beat));
                lat_pending = 1'b0;
            end
            if (stalled) begin
                checkOutput("stall_valid", 128'(out_valid), 128'(1));
                checkOutput("stall_beat", outVec(), stall_vec);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_beat", 128'(out_valid), 128'(0));
                end else begin
                    bt = exp_q.pop_front();
                    checkOutput("scoreboard_beat", outVec(), packBeat(bt));
                end
            end
            stalled   = out_valid && !out_ready;
            stall_vec = outVec();
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        errors++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [47:0] dst;
        for (int i = 0; i < NUM_ADDR; i++) begin
            addr_table[48*i +: 48] = ENTRY0 + (48'(i) << 40);
        end
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset_out_beat", outVec(), 128'(0));
        checkOutput("reset_pass_count", 128'(pass_count), 128'(0));
        checkOutput("reset_drop_count", 128'(drop_count), 128'(0));
        checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
        mon_en = 1'b1;
        @(negedge Clock);

        $display("[TB] unicast table hit");
        addr_enable = 4'b0001;
        sendFrame(ENTRY0, 3, 8'hff, 0);
        idle(3);
        checkOutput("ucast_pass_count", 128'(pass_count), 128'(1));
        checkCounts("ucast");

        $display("[TB] disabled entry drops, then re-enabled passes");
        addr_enable = '0;
        sendFrame(ENTRY0, 3, 8'hff, 0);
        idle(3);
        checkOutput("disabled_drop_count", 128'(drop_count), 128'(1));
        checkCounts("disabled");
        addr_enable = 4'b0001;
        sendFrame(ENTRY0, 2, 8'hff, 0);
        idle(3);
        checkCounts("reenabled");

        $display("[TB] broadcast and multicast modes");
        accept_multicast = 1'b1;
        sendFrame(BCAST, 2, 8'hff, 0);
        sendFrame(MCAST, 2, 8'hff, 0);
        accept_broadcast = 1'b1;
        sendFrame(BCAST, 1, 8'hff, 0);
        idle(3);
        checkOutput("group_pass_count", 128'(pass_count), 128'(4));
        checkOutput("group_drop_count", 128'(drop_count), 128'(2));
        checkCounts("group");

        $display("[TB] runt first beat under promiscuous");
        promiscuous = 1'b1;
        sendFrame(OTHER, 2, 8'h1f, 0);
        idle(3);
        checkOutput("runt_drop_count", 128'(drop_count), 128'(3));
        checkCounts("runt");
        promiscuous = 1'b0;
        accept_broadcast = 1'b0;
        accept_multicast = 1'b0;

        $display("[TB] reset in the middle of a passed frame");
        begin
            beat_t bt;
            bt.data = {16'h1234, ENTRY0};
            bt.keep = 8'hff;
            bt.last = 1'b0;
            bt.user = 1'b1;
            applyStimulus(bt, 0);
        end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        m_pass   = '0;
        m_drop   = '0;
        in_frame = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 128'(out_valid), 128'(0));
        checkOutput("midreset_pass_count", 128'(pass_count), 128'(0));
        checkOutput("midreset_drop_count", 128'(drop_count), 128'(0));
        @(negedge Clock);
        sendFrame(OTHER, 2, 8'hff, 0);
        idle(3);
        checkOutput("after_reset_drop_count", 128'(drop_count), 128'(1));
        checkCounts("after_reset");

        $display("[TB] count_clear coinciding with a frame start");
        count_clear = 1'b1;
        sendFrame(ENTRY0, 1, 8'hff, 0);
        count_clear = 1'b0;
        idle(3);
        checkOutput("clear_pass_count", 128'(pass_count), 128'(0));
        checkCounts("clear");

        $display("[TB] drop counter wrap");
        force dut.drop_count = 32'hffff_ffff;
        #1;
        release dut.drop_count;
        m_drop = 32'hffff_ffff;
        #1;
        checkOutput("wrap_preset", 128'(drop_count), 128'(32'hffff_ffff));
        @(negedge Clock);
        sendFrame(OTHER, 1, 8'hff, 0);
        idle(2);
        checkOutput("wrap_drop_count", 128'(drop_count), 128'(0));
        checkCounts("wrap");

        $display("[TB] randomized frames with output backpressure");
        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            addr_enable      = 4'($urandom);
            accept_broadcast = 1'($urandom);
            accept_multicast = 1'($urandom);
            promiscuous      = ($urandom_range(0, 99) < 15);
            case ($urandom_range(0, 4))
                0, 1:    dst = ENTRY0 + (48'($urandom_range(0, NUM_ADDR - 1)) << 40);
                2:       dst = BCAST;
                3:       dst = {16'($urandom), $urandom} | 48'h1;
                default: dst = {16'($urandom), $urandom} & ~48'h1;
            endcase
            sendFrame(dst, $urandom_range(1, 5),
                      ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hff, 2);
        end
        rand_ready = 1'b0;
        idle(5);
        checkCounts("random");

        finishTest();
    end

endmodule

// File: doc/eth_dest_filter.md
# eth_dest_filter

Parametrised Ethernet destination-address filter on the receive stream path, between the MAC receive interface and the packet FIFO / protocol parsers. It inspects the destination MAC of each frame and passes or drops the whole frame. Acceptance is based on a table of unicast addresses, broadcast, multicast and promiscuous modes. Passed frames leave through a one-stage registered AXI-Stream output at full throughput; per-frame pass/drop counters are provided for status.

## Interface
- DATA_W, 64, stream data width in bits; multiple of 8, >= 64 so the destination MAC fits in the first beat.
- NUM_ADDR, 4, number of unicast address table entries (1..16).
- USER_W, 1, sideband width carried with each beat.
- Clock  in  1  clock; all logic on the rising edge.
- Reset  in  1  reset, synchronous, active-high.
- in_valid, in_ready  in/out  1  upstream handshake.
- in_data  in  DATA_W  beat data; byte 0 (first on the wire) is bits [7:0].
- in_keep  in  DATA_W/8  byte enables.
- in_last  in  1  last beat of frame.
- in_user  in  USER_W  sideband.
- out_valid, out_ready  out/in  1  downstream handshake.
- out_data, out_keep, out_last, out_user  out  as input  registered copies of passed beats.
- addr_table  in  48*NUM_ADDR  entry i at [48*i+47:48*i], same byte order as in_data[47:0].
- addr_enable  in  NUM_ADDR  per-entry enable.
- accept_broadcast  in  1  pass destination ff:ff:ff:ff:ff:ff.
- accept_multicast  in  1  pass any group address (in_data[0]=1) other than broadcast.
- promiscuous  in  1  pass every frame that is not a runt.
- count_clear  in  1  synchronous clear of both counters.
- pass_count, drop_count  out  32  frames passed / dropped since reset or clear.

## Operation
- The beat transfer condition is `take = in_valid && in_ready`. `in_ready = !out_valid || out_ready` at all times, including while dropping.
- The state machine has three states: FIRST (reset state), PASS, DROP. Transitions occur only on `take`:
  - FIRST: if in_last, stay in FIRST; else go to PASS if the frame matches, otherwise DROP.
  - PASS or DROP: if in_last, go to FIRST; else stay.
- The match decision is made combinationally on the FIRST-state beat, using only that beat and the configuration at that cycle. The configuration is ignored for the rest of the frame.
  - `runt` = in_keep[5:0] != 6'h3f.
  - `ucast` = OR over i of (addr_enable[i] && in_data[47:0]==entry i).
  - `bcast` = accept_broadcast && in_data[47:0]==48'hffff_ffff_ffff.
  - `mcast` = accept_multicast && in_data[0] && in_data[47:0]!=all-ones.
  - `match` = !runt && (promiscuous || ucast || bcast || mcast).
- A beat is passed if it is taken and either (FIRST state and match) or PASS state. A passed beat loads out_data/keep/last/user, and out_valid is set.
- Dropped beats are consumed without loading the output register.
- out_valid clears on `out_valid && out_ready` with no passed beat in the same cycle. A simultaneous output drain and passed beat reloads the register, and out_valid stays 1.
- Counters update only on a FIRST-state `take`: pass_count+1 if match, otherwise drop_count+1. Both are 32-bit and wrap from 0xffff_ffff to 0.
- count_clear has priority: if count_clear is high, both counters become 0 in that cycle and any coinciding increment is lost.
- Reset mid-frame returns the FSM to FIRST. The next beat is treated as a frame start. Upstream is responsible for frame realignment.

## Timing
- Reset values: out_valid=0, out_data/keep/last/user=0, pass_count=drop_count=0, state FIRST.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_* to out_*.
- Latency is 1 cycle from a passed `take` to out_valid/out_data.
- Throughput is 1 beat per cycle with out_ready held high. Dropped frames consume 1 beat per cycle.
- Under backpressure (out_valid=1, out_ready=0), in_ready=0 and nothing is taken, including beats of frames being dropped.
- out_* stay stable while out_valid=1 and out_ready=0.
- Counter values are visible the cycle after the deciding `take`.
- A single-beat frame (in_last on the FIRST beat) is decided and counted, and the FSM stays in FIRST.

## Test plan
- Entry 0 = 02:00:00:00:00:01 (in_data[47:0]=48'h0100_0000_0002), enabled; send a 3-beat frame to it -> 3 beats out, identical data/keep/last/user, each 1 cycle after `take`; pass_count=1.
- Same frame with addr_enable=0 and all modes off -> no out_valid; in_ready stays 1; drop_count=1; the next matching frame passes intact.
- Broadcast frame with accept_broadcast=0, accept_multicast=1 -> dropped. Frame to 01:00:5e:00:00:01 -> passed. Set accept_broadcast=1 -> broadcast passed.
- First beat in_keep=8'h1f with promiscuous=1 -> dropped as runt; drop_count increments.
- Random out_ready toggling over 200 random frames -> output equals a scoreboard of the matching frames; no beat lost or duplicated; out_* stable while stalled.
- Assert Reset mid-PASS-frame -> out_valid=0 and counters 0 next cycle; next beat treated as first. Set count_clear on the same cycle as a FIRST `take` -> counters read 0. Preset drop_count to 0xffff_ffff via 2^32 drops (or force) -> the next drop wraps it to 0.
